queue_access_arbiter: RTL

// - Shares the single RAM-queue command port (active/cmd/data_in -> data_out/overflow/underflow) between two requesters.

---
 rtl/qarb_pkg.sv | 19 +
 rtl/qarb_rr_pick.sv | 40 ++++
 rtl/queue_access_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/qarb_pkg.sv
// Shared types and constants for the two-requester queue access arbiter.
// The build option QARB_FIXED_PRIO_EN is consumed by qarb_rr_pick.
package qarb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } qarb_state_t;

    localparam logic CMD_PUSH = 1'b1;
    localparam logic CMD_POP  = 1'b0;

    function automatic int unsigned qarb_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/qarb_rr_pick.sv
// Two-way request picker: round-robin by default, fixed priority (req0 first)
// when QARB_FIXED_PRIO_EN is defined.
module qarb_rr_pick (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    input  logic       i_advance,
    output logic [1:0] o_grant,
    output logic       o_ptr_next
);

`ifdef QARB_FIXED_PRIO_EN
    logic w_unused_rr;

    always_comb begin
        o_grant = 2'b00;
        if (i_req[0]) begin
            o_grant = 2'b01;
        end else if (i_req[1]) begin
            o_grant = 2'b10;
        end
    end

    assign o_ptr_next  = 1'b0;
    assign w_unused_rr = ^{i_ptr, i_advance};
`else
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_ptr ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

    // After a grant the pointer names the requester that did not win.
    assign o_ptr_next = (i_advance && (|i_req)) ? o_grant[0] : i_ptr;
`endif

endmodule

// File: rtl/queue_access_arbiter.sv
// Shares one RAM-queue command port between two requesters via req/gnt/done,
// mirroring occupancy to reject impossible ops. Option: QARB_FIXED_PRIO_EN.
module queue_access_arbiter
    import qarb_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  cmd0,
    input  logic                  cmd1,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] din1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  q_active,
    output logic                  q_cmd,
    output logic [DATA_WIDTH-1:0] q_data_in,
    input  logic [DATA_WIDTH-1:0] q_data_out,
    input  logic                  q_overflow,
    input  logic                  q_underflow,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  busy
);

    localparam int          CW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = qarb_depth(ADDR_WIDTH);

    qarb_state_t           r_state;
    qarb_state_t           w_state_next;
    logic                  r_ptr;
    logic [1:0]            r_owner;
    logic                  r_cmd;
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_legal;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_err;

    logic [1:0]            w_req;
    logic [1:0]            w_grant;
    logic                  w_ptr_next;
    logic                  w_advance;
    logic                  w_legal;
    logic                  w_op_err;

    assign w_req     = {req1, req0};
    assign w_advance = (r_state == IDLE) && (|w_req);

    qarb_rr_pick u_pick (
        .i_req      (w_req),
        .i_ptr      (r_ptr),
        .i_advance  (w_advance),
        .o_grant    (w_grant),
        .o_ptr_next (w_ptr_next)
    );

    // Legality is judged against the mirrored occupancy, which only moves at the end of WAIT.
    assign w_legal  = (r_cmd == CMD_PUSH) ? (r_count < CW'(DEPTH)) : (r_count != '0);
    assign w_op_err = !r_legal || q_overflow || q_underflow;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (|w_req) w_state_next = ISSUE;
            ISSUE:   w_state_next = WAIT;
            WAIT:    w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= 1'b0;
            r_owner    <= 2'b00;
            r_cmd      <= 1'b0;
            r_din      <= '0;
            r_legal    <= 1'b0;
            r_count    <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_owner <= w_grant;
                        r_cmd   <= w_grant[1] ? cmd1 : cmd0;
                        r_din   <= w_grant[1] ? din1 : din0;
                    end
                end
                ISSUE: begin
                    r_legal <= w_legal;
                end
                WAIT: begin
                    r_rsp_err <= w_op_err;
                    if (!w_op_err) begin
                        if (r_cmd == CMD_PUSH) begin
                            r_count <= r_count + CW'(1);
                        end else begin
                            r_count    <= r_count - CW'(1);
                            r_rsp_data <= q_data_out;
                        end
                    end
                end
                DONE: begin
                    r_owner <= 2'b00;
                end
                default: begin
                    r_owner <= 2'b00;
                end
            endcase
        end
    end

    assign gnt0      = r_owner[0];
    assign gnt1      = r_owner[1];
    assign done0     = (r_state == DONE) && r_owner[0];
    assign done1     = (r_state == DONE) && r_owner[1];
    assign q_active  = (r_state == ISSUE) && w_legal;
    assign q_cmd     = r_cmd;
    assign q_data_in = r_din;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign count     = r_count;
    assign busy      = (r_state != IDLE);

endmodule
